// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing record, counter width and load-validity rule
// for video_timing_gen.
package video_timing_pkg;
    localparam int VT_CW = 12;
    localparam int TW    = VT_CW + 2;
    localparam logic [TW-1:0] TMAX = TW'(2 ** VT_CW - 1);

    typedef struct packed {
        logic [VT_CW-1:0] h_active;
        logic [VT_CW-1:0] h_fp;
        logic [VT_CW-1:0] h_sync;
        logic [VT_CW-1:0] h_bp;
        logic [VT_CW-1:0] v_active;
        logic [VT_CW-1:0] v_fp;
        logic [VT_CW-1:0] v_sync;
        logic [VT_CW-1:0] v_bp;
        logic             interlace;
    } timing_t;

    function automatic logic [TW-1:0] h_total(timing_t t);
        return TW'(t.h_active) + TW'(t.h_fp) + TW'(t.h_sync) + TW'(t.h_bp);
    endfunction

    function automatic logic [TW-1:0] v_total(timing_t t);
        return TW'(t.v_active) + TW'(t.v_fp) + TW'(t.v_sync) + TW'(t.v_bp);
    endfunction

    function automatic logic timing_valid(timing_t t);
        return t.h_active != '0 && t.h_sync != '0 && t.v_active != '0 && t.v_sync != '0
            && h_total(t) <= TMAX && v_total(t) <= TMAX;
    endfunction
endpackage

// File: rtl/video_timing_ce.sv
// video_timing_ce: pixel clock-enable divider, one pulse every CE_DIV+1 clocks.
// A new CE_DIV is adopted at each divider wrap; the first period uses the live value.
module video_timing_ce (
    input  logic       CLK_VIDEO,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic [3:0] CE_DIV,
    output logic       CE_PIXEL
);
    logic [3:0] cnt, div, d;
    logic       run;

    assign d = run ? div : CE_DIV;

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt      <= '0;
            div      <= '0;
            run      <= 1'b0;
            CE_PIXEL <= 1'b0;
        end else begin
            run      <= ENABLE;
            cnt      <= (!ENABLE || cnt == d) ? '0 : cnt + 4'd1;
            div      <= (cnt == d) ? CE_DIV : d;
            CE_PIXEL <= ENABLE && cnt == d;
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with frame-boundary shadowed timing.
// Define VIDEO_TIMING_GEN_INTERLACE_EN for interlaced fields with half-line vsync; CW must equal VT_CW.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CW = VT_CW
) (
    input  logic          CLK_VIDEO,
    input  logic          RESET_N,
    input  logic          ENABLE,
    input  logic [3:0]    CE_DIV,
    input  logic [CW-1:0] H_ACTIVE,
    input  logic [CW-1:0] H_FP,
    input  logic [CW-1:0] H_SYNC,
    input  logic [CW-1:0] H_BP,
    input  logic [CW-1:0] V_ACTIVE,
    input  logic [CW-1:0] V_FP,
    input  logic [CW-1:0] V_SYNC,
    input  logic [CW-1:0] V_BP,
    input  logic          INTERLACE,
    output logic          CE_PIXEL,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE,
    output logic          HBLANK,
    output logic          VBLANK,
    output logic [CW-1:0] HCNT,
    output logic [CW-1:0] VCNT,
    output logic          FIELD,
    output logic          NEW_FRAME
);
    timing_t       tin, sh, sh_n;
    logic          sh_ok, en_q, rise, in_ok, run_n, origin;
    logic          step, h_last, v_last, wrap, load, vs_now, vs_n;
    logic [CW-1:0] hcnt_n, vcnt_n;
    logic [TW-1:0] hn, vn, hs0, hs1, vs0, vs1;

    assign tin    = {H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, INTERLACE};
    assign in_ok  = timing_valid(tin);
    assign rise   = ENABLE & ~en_q;
    assign run_n  = ENABLE & (sh_ok | (rise & in_ok));
    assign step   = ENABLE & CE_PIXEL;
    assign h_last = TW'(HCNT) == h_total(sh) - TW'(1);
    assign v_last = TW'(VCNT) == v_total(sh) - TW'(1) + TW'(FIELD);
    assign wrap   = step & h_last & v_last;
    assign load   = ENABLE & in_ok & (rise | wrap);
    assign sh_n   = load ? tin : sh;
    assign hcnt_n = !ENABLE ? '0 : !step ? HCNT : h_last ? '0 : HCNT + CW'(1);
    assign vcnt_n = !ENABLE ? '0 : !(step && h_last) ? VCNT : v_last ? '0 : VCNT + CW'(1);

    // Strobes are decoded from next-state counters and the shadow that will be live then.
    always_comb begin
        hn  = TW'(hcnt_n);
        vn  = TW'(vcnt_n);
        hs0 = TW'(sh_n.h_active) + TW'(sh_n.h_fp);
        hs1 = hs0 + TW'(sh_n.h_sync);
        vs0 = TW'(sh_n.v_active) + TW'(sh_n.v_fp);
        vs1 = vs0 + TW'(sh_n.v_sync);
    end

    assign vs_now = vn >= vs0 && vn < vs1;

`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
    logic fld_n, vs_prev;

    // On line 0 the subtraction wraps high, so the previous-line test is false.
    assign vs_prev = vn - TW'(1) >= vs0 && vn - TW'(1) < vs1;
    assign fld_n   = !ENABLE ? 1'b0 : wrap ? sh_n.interlace & ~FIELD : FIELD;
    assign vs_n    = (fld_n && hn < (h_total(sh_n) >> 1)) ? vs_prev : vs_now;

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N)
            FIELD <= 1'b0;
        else
            FIELD <= fld_n;
    end
`else
    assign vs_n  = vs_now;
    assign FIELD = 1'b0;
`endif

    video_timing_ce u_ce (
        .CLK_VIDEO (CLK_VIDEO),
        .RESET_N   (RESET_N),
        .ENABLE    (run_n),
        .CE_DIV    (CE_DIV),
        .CE_PIXEL  (CE_PIXEL)
    );

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            sh     <= '0;
            sh_ok  <= 1'b0;
            en_q   <= 1'b0;
            HCNT   <= '0;
            VCNT   <= '0;
            origin <= 1'b0;
            VGA_HS <= 1'b0;
            VGA_VS <= 1'b0;
            VGA_DE <= 1'b0;
            HBLANK <= 1'b0;
            VBLANK <= 1'b0;
        end else begin
            sh     <= sh_n;
            sh_ok  <= sh_ok | load;
            en_q   <= ENABLE;
            HCNT   <= hcnt_n;
            VCNT   <= vcnt_n;
            origin <= run_n && hcnt_n == '0 && vcnt_n == '0;
            VGA_HS <= run_n && hn >= hs0 && hn < hs1;
            VGA_VS <= run_n && vs_n;
            VGA_DE <= run_n && hn < TW'(sh_n.h_active) && vn < TW'(sh_n.v_active);
            HBLANK <= run_n && hn >= TW'(sh_n.h_active);
            VBLANK <= run_n && vn >= TW'(sh_n.v_active);
        end
    end

    assign NEW_FRAME = CE_PIXEL & origin;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized self-checking bench; the model tracks a pixel
// position within the frame and derives counters and strobes by division.
module tb_video_timing_gen;
    localparam int CW = 12;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, il;
    } tm_t;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, il = 1'b0;
    logic [3:0]    div = 4'd0;
    logic [CW-1:0] h_act, h_fp, h_sw, h_bp, v_act, v_fp, v_sw, v_bp;
    logic          ce, hsync, vsync, de, hbl, vbl, fld, nf;
    logic [CW-1:0] hc, vc;

    int  n_cmp = 0, n_bad = 0;
    tm_t mt;
    bit  m_ok, m_enq, m_run, m_ce, m_fld;
    int  m_k, m_d, m_p;

    always #5 clk = ~clk;

    video_timing_gen #(.CW(CW)) dut (
        .CLK_VIDEO (clk),   .RESET_N (rst_n), .ENABLE (en),     .CE_DIV (div),
        .H_ACTIVE  (h_act), .H_FP    (h_fp),  .H_SYNC (h_sw),   .H_BP   (h_bp),
        .V_ACTIVE  (v_act), .V_FP    (v_fp),  .V_SYNC (v_sw),   .V_BP   (v_bp),
        .INTERLACE (il),    .CE_PIXEL (ce),   .VGA_HS (hsync),  .VGA_VS (vsync),
        .VGA_DE    (de),    .HBLANK  (hbl),   .VBLANK (vbl),    .HCNT   (hc),
        .VCNT      (vc),    .FIELD   (fld),   .NEW_FRAME (nf)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic tm_t cur_in();
        tm_t t;
        t = '{int'(h_act), int'(h_fp), int'(h_sw), int'(h_bp),
              int'(v_act), int'(v_fp), int'(v_sw), int'(v_bp), int'(il)};
        return t;
    endfunction

    function automatic int htot(tm_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int vtot(tm_t t);
        return t.va + t.vf + t.vs + t.vb;
    endfunction

    function automatic bit valid(tm_t t);
        return t.ha > 0 && t.hs > 0 && t.va > 0 && t.vs > 0 && htot(t) <= 4095 && vtot(t) <= 4095;
    endfunction

    task automatic model_reset();
        m_ok = 0; m_enq = 0; m_run = 0; m_ce = 0; m_fld = 0; m_k = 0; m_d = 0; m_p = 0;
    endtask

    task automatic model_edge();
        tm_t t;
        t = cur_in();
        if (!en) begin
            m_run = 0; m_p = 0; m_fld = 0; m_ce = 0; m_k = 0;
        end else if (!m_enq) begin
            if (valid(t)) begin
                mt = t;
                m_ok = 1;
            end
            m_run = m_ok; m_p = 0; m_fld = 0; m_d = int'(div); m_k = 1;
            m_ce = m_run && m_d == 0;
        end else if (m_run) begin
            if (m_ce) begin
                m_p++;
                if (m_p == htot(mt) * (vtot(mt) + int'(m_fld))) begin
                    m_p = 0;
                    if (valid(t)) mt = t;
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
                    m_fld = (mt.il != 0) ? !m_fld : 1'b0;
`endif
                end
            end
            m_k++;
            m_ce = (m_k % (m_d + 1)) == 0;
        end
        m_enq = en;
    endtask

    task automatic compare();
        int ht, h, v, q, vs0, hs0;
        bit e_hs, e_vs, e_hb, e_vb;
        h = 0; v = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
        if (m_run) begin
            ht   = htot(mt);
            h    = m_p % ht;
            v    = m_p / ht;
            e_hb = h >= mt.ha;
            e_vb = v >= mt.va;
            hs0  = mt.ha + mt.hf;
            e_hs = h >= hs0 && h < hs0 + mt.hs;
            vs0  = mt.va + mt.vf;
            q    = m_fld ? m_p - ht / 2 : m_p;
            e_vs = q >= 0 && q / ht >= vs0 && q / ht < vs0 + mt.vs;
        end
        check("ce", int'(ce), int'(m_ce));
        check("hcnt", int'(hc), h);
        check("vcnt", int'(vc), v);
        check("hs", int'(hsync), int'(e_hs));
        check("vs", int'(vsync), int'(e_vs));
        check("hblank", int'(hbl), int'(e_hb));
        check("vblank", int'(vbl), int'(e_vb));
        check("de", int'(de), int'(m_run && !e_hb && !e_vb));
        check("field", int'(fld), int'(m_fld));
        check("new_frame", int'(nf), int'(m_run && m_ce && m_p == 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic chk_zero();
        check("rst_ce", int'(ce), 0);
        check("rst_hcnt", int'(hc), 0);
        check("rst_vcnt", int'(vc), 0);
        check("rst_hs", int'(hsync), 0);
        check("rst_vs", int'(vsync), 0);
        check("rst_de", int'(de), 0);
        check("rst_hblank", int'(hbl), 0);
        check("rst_vblank", int'(vbl), 0);
        check("rst_field", int'(fld), 0);
        check("rst_new_frame", int'(nf), 0);
    endtask

    task automatic set_t(input int a, b, c, d, e, f, g, k);
        h_act = CW'(a); h_fp = CW'(b); h_sw = CW'(c); h_bp = CW'(d);
        v_act = CW'(e); v_fp = CW'(f); v_sw = CW'(g); v_bp = CW'(k);
    endtask

    task automatic rand_t(input bit good);
        set_t($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
              $urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(1, 2), $urandom_range(0, 2));
        il = 1'($urandom_range(0, 1));
        if (!good) begin
            case ($urandom_range(0, 2))
                0:       v_sw = '0;
                1:       begin h_act = 12'd4000; h_fp = 12'd100; h_sw = 12'd100; end
                default: h_act = '0;
            endcase
        end
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1 chk_zero();
        model_reset();
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        set_t(640, 16, 96, 48, 480, 10, 2, 33);
        repeat (3) @(posedge clk);
        #1 chk_zero();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();

        en = 1'b1;
        repeat (2000) step();

        en = 1'b0;
        step();
        div = 4'd3;
        en = 1'b1;
        repeat (3500) step();

        en = 1'b0;
        step();
        div = 4'd0;
        set_t(16, 2, 3, 3, 10, 1, 1, 2);
        il = 1'b0;
        en = 1'b1;
        repeat (100) step();
        h_act = 12'd8;
        repeat (700) step();
        set_t(4000, 100, 100, 3, 10, 1, 1, 2);
        repeat (700) step();
        set_t(16, 2, 3, 3, 10, 1, 0, 2);
        repeat (700) step();

        en = 1'b0;
        step();
        rand_t(1'b1);
        div = 4'($urandom_range(0, 3));
        en = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            step();
            if ($urandom_range(0, 49) == 0) rand_t($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1999) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 4)) step();
                div = 4'($urandom_range(0, 3));
                en = 1'b1;
            end
        end

`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
        en = 1'b0;
        step();
        div = 4'd0;
        set_t(20, 2, 4, 4, 240, 3, 3, 16);
        il = 1'b1;
        en = 1'b1;
        repeat (16000) step();
`endif

        async_reset();
        set_t(16, 2, 3, 3, 10, 1, 1, 2);
        div = 4'd1;
        step();
        en = 1'b1;
        repeat (300) step();

        async_reset();
        v_sw = '0;
        step();
        en = 1'b1;
        repeat (50) step();
        en = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
